// File: rtl/phase_gen.sv
// -----------------------------------------------------------------------------
// phase_gen
//
// FM operator phase accumulator. Once per accepted sample strobe the phase
// register advances by the tuning word plus a signed, left-shifted modulation
// term. The top ADDR_BITS+2 phase bits leave as an unmapped sine-LUT address:
// the two MSBs pick the quadrant, the low ADDR_BITS index the quarter-wave table.
//
// Ports
//   clk          in   1             system clock, rising edge
//   rst_n        in   1             synchronous active-low reset
//   sample_en    in   1             one-cycle sample-rate strobe
//   note_on      in   1             level, high while the operator runs
//   tuning_word  in   ACC_BITS      unsigned phase increment per sample
//   mod_in       in   MOD_BITS      signed modulation input
//   mod_shift    in   4             left shift applied to sign-extended mod_in
//   addr_out     out  ADDR_BITS+2   phase[ACC_BITS-1 -: ADDR_BITS+2]
//   addr_valid   out  1             one-cycle pulse, addr_out is new
//   active       out  1             high in the run state
//   overrun      out  1             sticky, strobe arrived while pipeline busy
//
// Update pipeline (strobe sampled at the edge closing cycle n):
//   cycle n+1 : r_inc holds tuning_word + (sext(mod_in) << mod_shift)
//   cycle n+2 : r_phase holds phase + inc, addr_out updated, addr_valid high
// -----------------------------------------------------------------------------
module phase_gen #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned ACC_BITS  = 32,  // must be >= ADDR_BITS+2 and > MOD_BITS
  parameter int unsigned MOD_BITS  = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_en,
  input  logic                   note_on,
  input  logic [ACC_BITS-1:0]    tuning_word,
  input  logic [MOD_BITS-1:0]    mod_in,
  input  logic [3:0]             mod_shift,
  output logic [ADDR_BITS+1:0]   addr_out,
  output logic                   addr_valid,
  output logic                   active,
  output logic                   overrun
);

  localparam int unsigned OutBits = ADDR_BITS + 2;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun
  } state_t;

  // State and datapath registers
  state_t              r_state;
  logic [ACC_BITS-1:0] r_phase;
  logic [ACC_BITS-1:0] r_inc;
  logic                r_s1;      // r_inc holds an increment waiting for stage 2
  logic                r_valid;   // stage 2 completed this cycle
  logic [OutBits-1:0]  r_addr;
  logic                r_overrun;

  // Next-state values
  state_t              w_state_next;
  logic [ACC_BITS-1:0] w_phase_next;
  logic [ACC_BITS-1:0] w_inc_next;
  logic                w_s1_next;
  logic                w_valid_next;
  logic [OutBits-1:0]  w_addr_next;
  logic                w_overrun_next;

  // Arithmetic
  logic [ACC_BITS-1:0] w_mod_sext;
  logic [ACC_BITS-1:0] w_mod_term;
  logic [ACC_BITS-1:0] w_inc_calc;
  logic [ACC_BITS-1:0] w_phase_sum;
  logic                w_busy;

  // Sign-extend first, then shift: bits pushed above ACC_BITS are simply lost,
  // which keeps the modulation term a plain modulo-2^ACC_BITS value.
  assign w_mod_sext  = {{(ACC_BITS - MOD_BITS){mod_in[MOD_BITS-1]}}, mod_in};
  assign w_mod_term  = w_mod_sext << mod_shift;
  assign w_inc_calc  = tuning_word + w_mod_term;
  assign w_phase_sum = r_phase + r_inc;

  // A strobe landing in cycle n+1 or n+2 of an update cannot be taken.
  assign w_busy = r_s1 | r_valid;

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_phase_next   = r_phase;
    w_inc_next     = r_inc;
    w_s1_next      = 1'b0;
    w_valid_next   = 1'b0;
    w_addr_next    = r_addr;
    w_overrun_next = r_overrun;

    case (r_state)
      StIdle: begin
        // Strobes are ignored here and do not count as overruns.
        w_phase_next = '0;
        w_inc_next   = '0;
        if (note_on) begin
          w_state_next = StArm;
        end
      end

      StArm: begin
        if (!note_on) begin
          w_state_next = StIdle;
          w_phase_next = '0;
          w_inc_next   = '0;
        end else if (sample_en) begin
          // First sample of a note: push a zero increment through the normal
          // pipeline so address 0 appears with the same latency as in run.
          w_phase_next = '0;
          w_inc_next   = '0;
          w_s1_next    = 1'b1;
          w_state_next = StRun;
        end
      end

      StRun: begin
        if (!note_on) begin
          // Note release drops any in-flight update; addr_out keeps its value.
          w_state_next = StIdle;
          w_phase_next = '0;
          w_inc_next   = '0;
        end else begin
          if (r_s1) begin
            w_phase_next = w_phase_sum;
            w_addr_next  = w_phase_sum[ACC_BITS-1 -: OutBits];
            w_valid_next = 1'b1;
          end
          if (sample_en) begin
            if (w_busy) begin
              w_overrun_next = 1'b1;
            end else begin
              w_inc_next = w_inc_calc;
              w_s1_next  = 1'b1;
            end
          end
        end
      end

      default: begin
        w_state_next = StIdle;
        w_phase_next = '0;
        w_inc_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_phase   <= '0;
      r_inc     <= '0;
      r_s1      <= 1'b0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_phase   <= w_phase_next;
      r_inc     <= w_inc_next;
      r_s1      <= w_s1_next;
      r_valid   <= w_valid_next;
      r_addr    <= w_addr_next;
      r_overrun <= w_overrun_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign addr_out   = r_addr;
  assign addr_valid = r_valid;
  assign active     = (r_state == StRun);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_phase_gen
//
// Directed bench for phase_gen (ADDR_BITS=12, ACC_BITS=32, MOD_BITS=18).
// Inputs are driven just after falling edges, outputs sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_phase_gen;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic        note_on;
  logic [31:0] tuning_word;
  logic [17:0] mod_in;
  logic [3:0]  mod_shift;
  logic [13:0] addr_out;
  logic        addr_valid;
  logic        active;
  logic        overrun;

  int n_checks;
  int n_errors;

  phase_gen #(
    .ADDR_BITS (12),
    .ACC_BITS  (32),
    .MOD_BITS  (18)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .note_on     (note_on),
    .tuning_word (tuning_word),
    .mod_in      (mod_in),
    .mod_shift   (mod_shift),
    .addr_out    (addr_out),
    .addr_valid  (addr_valid),
    .active      (active),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge. One strobe, then checks the pulse lands
  // exactly in cycle n+2 and is one cycle wide. Inputs are scrambled after the
  // strobe cycle so late sampling would show up. Total spacing is 8 cycles.
  task automatic strobe_chk(input string tag, input logic [31:0] tw, input logic [17:0] mi,
                            input logic [3:0] sh, input logic [13:0] exp_addr);
    sample_en   = 1'b1;
    tuning_word = tw;
    mod_in      = mi;
    mod_shift   = sh;
    @(negedge clk);
    sample_en   = 1'b0;
    tuning_word = 32'hDEAD_BEEF;
    mod_in      = 18'h2AAAA;
    mod_shift   = 4'hF;
    check_eq({tag, ":vld_n1"}, addr_valid, 32'd0);
    @(negedge clk);
    check_eq({tag, ":vld_n2"}, addr_valid, 32'd1);
    check_eq({tag, ":addr"}, addr_out, exp_addr);
    check_eq({tag, ":active"}, active, 32'd1);
    @(negedge clk);
    check_eq({tag, ":vld_n3"}, addr_valid, 32'd0);
    check_eq({tag, ":addr_hold"}, addr_out, exp_addr);
    repeat (5) @(negedge clk);
  endtask

  // Release and re-press the note so the next strobe is taken in the arm state.
  task automatic restart_note();
    note_on = 1'b0;
    @(negedge clk);
    note_on = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    sample_en   = 1'b0;
    note_on     = 1'b1;
    tuning_word = 32'h0;
    mod_in      = 18'h0;
    mod_shift   = 4'h0;

    // 1: reset with strobes toggling and note held high
    repeat (4) begin
      @(negedge clk);
      sample_en = ~sample_en;
    end
    @(negedge clk);
    check_eq("rst:addr", addr_out, 32'd0);
    check_eq("rst:vld", addr_valid, 32'd0);
    check_eq("rst:active", active, 32'd0);
    check_eq("rst:overrun", overrun, 32'd0);
    rst_n     = 1'b1;
    note_on   = 1'b0;
    sample_en = 1'b0;
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("idle:vld", addr_valid, 32'd0);
      @(negedge clk);
    end
    check_eq("idle:overrun", overrun, 32'd0);
    check_eq("idle:active", active, 32'd0);

    // 2: linear ramp
    note_on = 1'b1;
    @(negedge clk);
    check_eq("arm:active", active, 32'd0);
    strobe_chk("lin0", 32'h0004_0000, 18'h0, 4'd0, 14'h0);
    strobe_chk("lin1", 32'h0004_0000, 18'h0, 4'd0, 14'h1);
    strobe_chk("lin2", 32'h0004_0000, 18'h0, 4'd0, 14'h2);
    strobe_chk("lin3", 32'h0004_0000, 18'h0, 4'd0, 14'h3);

    // 3: quadrant walk and wrap
    restart_note();
    strobe_chk("q_arm", 32'h4000_0000, 18'h0, 4'd0, 14'h0000);
    strobe_chk("q1", 32'h4000_0000, 18'h0, 4'd0, 14'h1000);
    strobe_chk("q2", 32'h4000_0000, 18'h0, 4'd0, 14'h2000);
    strobe_chk("q3", 32'h4000_0000, 18'h0, 4'd0, 14'h3000);
    strobe_chk("qwrap", 32'h4000_0000, 18'h0, 4'd0, 14'h0000);

    // 4: modulation. inc = 0x3FFFC, then 0x38000, then 0x48000
    restart_note();
    strobe_chk("m2_arm", 32'h0004_0000, 18'h3FFFF, 4'd2, 14'h0);
    strobe_chk("m2_a", 32'h0004_0000, 18'h3FFFF, 4'd2, 14'h0);
    strobe_chk("m2_b", 32'h0004_0000, 18'h3FFFF, 4'd2, 14'h1);
    strobe_chk("m2_c", 32'h0004_0000, 18'h3FFFF, 4'd2, 14'h2);
    restart_note();
    strobe_chk("mn15_arm", 32'h0004_0000, 18'h3FFFF, 4'd15, 14'h0);
    strobe_chk("mn15_a", 32'h0004_0000, 18'h3FFFF, 4'd15, 14'h0);  // 0x38000
    strobe_chk("mn15_b", 32'h0004_0000, 18'h3FFFF, 4'd15, 14'h1);  // 0x70000
    strobe_chk("mn15_c", 32'h0004_0000, 18'h3FFFF, 4'd15, 14'h2);  // 0xA8000
    strobe_chk("mn15_d", 32'h0004_0000, 18'h3FFFF, 4'd15, 14'h3);  // 0xE0000
    restart_note();
    strobe_chk("mp15_arm", 32'h0004_0000, 18'h00001, 4'd15, 14'h0);
    strobe_chk("mp15_a", 32'h0004_0000, 18'h00001, 4'd15, 14'h1);  // 0x48000
    strobe_chk("mp15_b", 32'h0004_0000, 18'h00001, 4'd15, 14'h2);  // 0x90000
    // Backwards from zero: inc = 0xFFFF8000
    restart_note();
    strobe_chk("bk_arm", 32'h0, 18'h3FFFF, 4'd15, 14'h0);
    strobe_chk("bk_a", 32'h0, 18'h3FFFF, 4'd15, 14'h3FFF);         // 0xFFFF8000
    strobe_chk("bk_b", 32'h0, 18'h3FFFF, 4'd15, 14'h3FFF);         // 0xFFFF0000
    // -2^17 << 15 = -2^32, truncates to 0; phase wraps to 0x00030000
    strobe_chk("trunc", 32'h0004_0000, 18'h20000, 4'd15, 14'h0);

    // 5: overrun, then note release mid-update
    restart_note();
    strobe_chk("ov_arm", 32'h0004_0000, 18'h0, 4'd0, 14'h0);
    sample_en   = 1'b1;
    tuning_word = 32'h0004_0000;
    mod_in      = 18'h0;
    mod_shift   = 4'd0;
    @(negedge clk);
    check_eq("ov:vld_n1", addr_valid, 32'd0);  // second strobe held high this cycle
    @(negedge clk);
    sample_en = 1'b0;
    check_eq("ov:vld_n2", addr_valid, 32'd1);
    check_eq("ov:addr", addr_out, 32'h1);
    check_eq("ov:flag", overrun, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("ov:no_second", addr_valid, 32'd0);
    end
    check_eq("ov:sticky", overrun, 32'd1);
    repeat (2) @(negedge clk);

    sample_en   = 1'b1;
    tuning_word = 32'h0004_0000;
    @(negedge clk);
    sample_en = 1'b0;
    note_on   = 1'b0;
    @(negedge clk);
    check_eq("rel:vld", addr_valid, 32'd0);
    check_eq("rel:active", active, 32'd0);
    check_eq("rel:addr_hold", addr_out, 32'h1);
    note_on = 1'b1;
    @(negedge clk);
    check_eq("rel:vld2", addr_valid, 32'd0);
    check_eq("rel:arm_inactive", active, 32'd0);
    strobe_chk("re_arm", 32'h0004_0000, 18'h0, 4'd0, 14'h0);
    strobe_chk("re_first", 32'h0004_0000, 18'h0, 4'd0, 14'h1);
    check_eq("rel:ov_sticky", overrun, 32'd1);

    // 6: reset in cycle n+1 of an update with note still high
    sample_en   = 1'b1;
    tuning_word = 32'h0004_0000;
    @(negedge clk);
    sample_en = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    check_eq("mrst:vld", addr_valid, 32'd0);
    check_eq("mrst:addr", addr_out, 32'd0);
    check_eq("mrst:active", active, 32'd0);
    check_eq("mrst:overrun", overrun, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mrst:vld_after", addr_valid, 32'd0);
    check_eq("mrst:arm_inactive", active, 32'd0);
    // Should already be armed: this strobe must be taken.
    strobe_chk("mrst_arm", 32'h0004_0000, 18'h0, 4'd0, 14'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
